// File: rtl/roce_qp_pkg.sv
// ---------------------------------------------------------------------------
// roce_qp_pkg
// Shared definitions for the RoCE QP transmit path: PSN width and type,
// QP transmit-controller state encoding, RC opcodes and modular PSN math.
// ---------------------------------------------------------------------------
package roce_qp_pkg;

    localparam int PSN_WIDTH = 24;

    typedef logic [PSN_WIDTH-1:0] psn_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_RETX  = 2'd2,
        ST_ERROR = 2'd3
    } qp_state_e;

    // RC transport opcodes used by the TX packet generator.
    localparam logic [7:0] RC_RDMA_WRITE_FIRST    = 8'h06;
    localparam logic [7:0] RC_RDMA_WRITE_MIDDLE   = 8'h07;
    localparam logic [7:0] RC_RDMA_WRITE_LAST     = 8'h08;
    localparam logic [7:0] RC_RDMA_WRITE_LAST_IMM = 8'h09;
    localparam logic [7:0] RC_RDMA_WRITE_ONLY     = 8'h0A;
    localparam logic [7:0] RC_RDMA_WRITE_ONLY_IMM = 8'h0B;
    localparam logic [7:0] RC_RDMA_ACK            = 8'h11;

    // (a - b) mod 2^24; the natural wrap of the 24-bit subtraction does it.
    function automatic psn_t psn_diff(input psn_t a, input psn_t b);
        return a - b;
    endfunction

endpackage

// File: rtl/roce_ack_timer.sv
// ---------------------------------------------------------------------------
// roce_ack_timer
// ACK timeout timer plus consecutive-retry counter for one QP.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   clear       zero timer and retry count (QP not in use)
//   progress    ACK progress seen: zero timer and retry count
//   enable      timer counts while high, held at zero while low
//   retry_inc   a retransmit is being issued: retries+1, timer zeroed
//   timeout     timer has reached TIMEOUT_CYCLES-1
//   exhausted   retry count equals MAX_RETRIES
// ---------------------------------------------------------------------------
module roce_ack_timer #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRIES    = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic progress,
    input  logic enable,
    input  logic retry_inc,
    output logic timeout,
    output logic exhausted
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retries_q, retries_d;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; that is what keeps latches from being inferred.
    always_comb begin
        timer_d   = timer_q;
        retries_d = retries_q;

        if (clear || !enable || progress || retry_inc) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        if (clear) begin
            retries_d = '0;
        end else begin
            if (progress) begin
                retries_d = '0;
            end
            // Caller only raises retry_inc when not exhausted, so no overflow.
            if (retry_inc) begin
                retries_d = retries_d + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q   <= '0;
            retries_q <= '0;
        end else begin
            timer_q   <= timer_d;
            retries_q <= retries_d;
        end
    end

    assign timeout   = (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign exhausted = (retries_q == RW'(MAX_RETRIES));

endmodule

// File: rtl/roce_tx_window_ctrl.sv
// ---------------------------------------------------------------------------
// roce_tx_window_ctrl
// Per-QP transmit flow controller: outstanding-PSN window, ACK timeout with
// bounded retries, go-back-N retransmit requests and fatal QP error.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   qp_open           QP connected, transfers permitted (level)
//   s_tx_pkt_valid    one-cycle strobe per BTH sent
//   s_tx_pkt_psn      PSN of that packet
//   last_acked_psn    latest acknowledged PSN from the state tracker
//   stop_transfer     NAK indication from the state tracker
//   tx_allow          generator may start a new packet
//   m_retx_valid      retransmit request (valid/ready)
//   m_retx_ready      retransmit request accepted
//   m_retx_psn        first PSN to replay
//   outstanding       (last_sent - last_acked) mod 2^24, registered
//   qp_error          retries exhausted; sticky until qp_open low
// ---------------------------------------------------------------------------
module roce_tx_window_ctrl
    import roce_qp_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 64,
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int MAX_RETRIES     = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 qp_open,
    input  logic                 s_tx_pkt_valid,
    input  logic [PSN_WIDTH-1:0] s_tx_pkt_psn,
    input  logic [PSN_WIDTH-1:0] last_acked_psn,
    input  logic                 stop_transfer,
    output logic                 tx_allow,
    output logic                 m_retx_valid,
    input  logic                 m_retx_ready,
    output logic [PSN_WIDTH-1:0] m_retx_psn,
    output logic [PSN_WIDTH-1:0] outstanding,
    output logic                 qp_error
);

    localparam psn_t MAX_OUT = PSN_WIDTH'(MAX_OUTSTANDING);

    qp_state_e state_q, state_d;
    psn_t      last_sent_q, last_sent_d;
    psn_t      acked_q, acked_d;
    psn_t      retx_psn_q, retx_psn_d;
    psn_t      outstanding_q, outstanding_d;

    logic ack_progress;
    logic run_event;
    logic timeout, exhausted;
    logic timer_clear, timer_progress, timer_enable, retry_inc;

    assign ack_progress = (last_acked_psn != acked_q);
    // ACK progress suppresses a coincident timeout; a NAK always counts.
    assign run_event    = stop_transfer || (timeout && !ack_progress);

    roce_ack_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES)
    ) u_ack_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (timer_clear),
        .progress  (timer_progress),
        .enable    (timer_enable),
        .retry_inc (retry_inc),
        .timeout   (timeout),
        .exhausted (exhausted)
    );

    always_comb begin
        state_d        = state_q;
        last_sent_d    = last_sent_q;
        acked_d        = last_acked_psn;
        retx_psn_d     = retx_psn_q;
        tx_allow       = 1'b0;
        timer_clear    = (state_q == ST_IDLE);
        timer_progress = 1'b0;
        timer_enable   = 1'b0;
        retry_inc      = 1'b0;

        // Sent PSNs are tracked in every active state, even with tx_allow low.
        if (state_q != ST_IDLE && s_tx_pkt_valid) begin
            last_sent_d = s_tx_pkt_psn;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (qp_open) begin
                    last_sent_d = last_acked_psn;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                timer_enable   = (outstanding_q != '0);
                timer_progress = ack_progress;
                tx_allow       = (outstanding_q < MAX_OUT) && !run_event;
                if (run_event) begin
                    if (exhausted) begin
                        state_d = ST_ERROR;
                    end else begin
                        retry_inc  = 1'b1;
                        retx_psn_d = last_acked_psn + 1'b1;
                        state_d    = ST_RETX;
                    end
                end
            end
            ST_RETX: begin
                // Go-back-N: everything past the last ACK is to be replayed.
                if (m_retx_ready) begin
                    last_sent_d = acked_q;
                    state_d     = ST_RUN;
                end
            end
            ST_ERROR: begin
            end
        endcase

        // Closing the QP overrides everything, including a pending request.
        if (!qp_open) begin
            state_d  = ST_IDLE;
            tx_allow = 1'b0;
        end

        outstanding_d = psn_diff(last_sent_d, acked_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_sent_q   <= '0;
            acked_q       <= '0;
            retx_psn_q    <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            last_sent_q   <= last_sent_d;
            acked_q       <= acked_d;
            retx_psn_q    <= retx_psn_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign m_retx_valid = (state_q == ST_RETX);
    assign m_retx_psn   = retx_psn_q;
    assign outstanding  = outstanding_q;
    assign qp_error     = (state_q == ST_ERROR);

endmodule

// File: tb/tb_roce_tx_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_roce_tx_window_ctrl
// Directed self-checking bench for roce_tx_window_ctrl with
// MAX_OUTSTANDING=64, TIMEOUT_CYCLES=100, MAX_RETRIES=2.
// ---------------------------------------------------------------------------
module tb_roce_tx_window_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        qp_open;
    logic        s_tx_pkt_valid;
    logic [23:0] s_tx_pkt_psn;
    logic [23:0] last_acked_psn;
    logic        stop_transfer;
    logic        tx_allow;
    logic        m_retx_valid;
    logic        m_retx_ready;
    logic [23:0] m_retx_psn;
    logic [23:0] outstanding;
    logic        qp_error;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    roce_tx_window_ctrl #(
        .MAX_OUTSTANDING (64),
        .TIMEOUT_CYCLES  (100),
        .MAX_RETRIES     (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .qp_open        (qp_open),
        .s_tx_pkt_valid (s_tx_pkt_valid),
        .s_tx_pkt_psn   (s_tx_pkt_psn),
        .last_acked_psn (last_acked_psn),
        .stop_transfer  (stop_transfer),
        .tx_allow       (tx_allow),
        .m_retx_valid   (m_retx_valid),
        .m_retx_ready   (m_retx_ready),
        .m_retx_psn     (m_retx_psn),
        .outstanding    (outstanding),
        .qp_error       (qp_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [23:0] psn);
        s_tx_pkt_valid = 1'b1;
        s_tx_pkt_psn   = psn;
        tick();
        s_tx_pkt_valid = 1'b0;
    endtask

    // Close then reopen the QP with a fresh acknowledged PSN.
    task automatic open_qp(input logic [23:0] acked);
        qp_open = 1'b0;
        tick();
        last_acked_psn = acked;
        qp_open        = 1'b1;
        tick();
    endtask

    task automatic stop_pulse();
        stop_transfer = 1'b1;
        tick();
        stop_transfer = 1'b0;
    endtask

    task automatic retx_handshake();
        m_retx_ready = 1'b1;
        tick();
        m_retx_ready = 1'b0;
    endtask

    initial begin
        logic [23:0] psn;
        int          stable;

        rst            = 1'b1;
        qp_open        = 1'b0;
        s_tx_pkt_valid = 1'b0;
        s_tx_pkt_psn   = '0;
        last_acked_psn = '0;
        stop_transfer  = 1'b0;
        m_retx_ready   = 1'b0;
        tick();
        tick();
        check("rst_tx_allow",    32'(tx_allow),     32'd0);
        check("rst_retx_valid",  32'(m_retx_valid), 32'd0);
        check("rst_retx_psn",    32'(m_retx_psn),   32'd0);
        check("rst_outstanding", 32'(outstanding),  32'd0);
        check("rst_qp_error",    32'(qp_error),     32'd0);
        rst = 1'b0;
        tick();

        // Window: 64 packets unacked closes the window, ACK to 0x30 reopens it.
        open_qp(24'h000010);
        check("open_outstanding", 32'(outstanding), 32'd0);
        check("open_tx_allow",    32'(tx_allow),    32'd1);
        for (int i = 0; i < 63; i++) send_pkt(24'h000011 + 24'(i));
        check("win63_outstanding", 32'(outstanding), 32'd63);
        check("win63_tx_allow",    32'(tx_allow),    32'd1);
        send_pkt(24'h000050);
        check("win64_outstanding", 32'(outstanding), 32'd64);
        check("win64_tx_allow",    32'(tx_allow),    32'd0);
        last_acked_psn = 24'h000030;
        tick();
        check("ack30_outstanding", 32'(outstanding), 32'd32);
        check("ack30_tx_allow",    32'(tx_allow),    32'd1);
        last_acked_psn = 24'h000050;
        tick();
        check("ack50_outstanding", 32'(outstanding), 32'd0);

        // PSN wrap: 0xFFFFF0 base, send 0xFFFFF1..0x000005 (21 packets).
        open_qp(24'hFFFFF0);
        psn = 24'hFFFFF0;
        for (int i = 0; i < 21; i++) begin
            psn = psn + 24'd1;
            send_pkt(psn);
        end
        check("wrap_last_psn",    32'(psn),         32'h000005);
        check("wrap_outstanding", 32'(outstanding), 32'h15);
        last_acked_psn = 24'h000005;
        tick();
        check("wrap_ack_outstanding", 32'(outstanding), 32'd0);

        // Timeout: one unacked packet, request appears 100 cycles later.
        open_qp(24'h000020);
        send_pkt(24'h000021);
        repeat (99) tick();
        check("to_before_valid", 32'(m_retx_valid), 32'd0);
        tick();
        check("to_valid",    32'(m_retx_valid), 32'd1);
        check("to_psn",      32'(m_retx_psn),   32'h000021);
        check("to_tx_allow", 32'(tx_allow),     32'd0);
        stable = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_retx_valid && m_retx_psn == 24'h000021) stable++;
        end
        check("to_hold_stable", 32'(stable), 32'd20);
        retx_handshake();
        check("to_hs_valid",       32'(m_retx_valid), 32'd0);
        check("to_hs_outstanding", 32'(outstanding),  32'd0);
        check("to_hs_tx_allow",    32'(tx_allow),     32'd1);

        // NAK: retransmit from last_acked+1 one cycle after the pulse.
        open_qp(24'h000040);
        stop_pulse();
        check("nak_valid", 32'(m_retx_valid), 32'd1);
        check("nak_psn",   32'(m_retx_psn),   32'h000041);
        retx_handshake();
        check("nak_hs_valid", 32'(m_retx_valid), 32'd0);

        // NAK coincident with timeout counts as a single retry: a further NAK
        // must still retransmit rather than exhaust MAX_RETRIES=2.
        open_qp(24'h000040);
        send_pkt(24'h000041);
        repeat (99) tick();
        stop_pulse();
        check("coin_valid", 32'(m_retx_valid), 32'd1);
        check("coin_psn",   32'(m_retx_psn),   32'h000041);
        retx_handshake();
        stop_pulse();
        check("coin_single_valid", 32'(m_retx_valid), 32'd1);
        check("coin_single_err",   32'(qp_error),     32'd0);
        retx_handshake();

        // Retry exhaustion by timeouts with no ACK at all.
        open_qp(24'h000060);
        for (int r = 0; r < 2; r++) begin
            send_pkt(24'h000061);
            repeat (100) tick();
            check($sformatf("ex%0d_valid", r), 32'(m_retx_valid), 32'd1);
            check($sformatf("ex%0d_psn", r),   32'(m_retx_psn),   32'h000061);
            retx_handshake();
        end
        send_pkt(24'h000061);
        repeat (100) tick();
        check("ex_qp_error", 32'(qp_error),     32'd1);
        check("ex_tx_allow", 32'(tx_allow),     32'd0);
        check("ex_valid",    32'(m_retx_valid), 32'd0);
        qp_open = 1'b0;
        tick();
        check("ex_close_qp_error", 32'(qp_error), 32'd0);

        // Close during RETX without handshake aborts the request.
        open_qp(24'h000070);
        stop_pulse();
        check("abort_pre_valid", 32'(m_retx_valid), 32'd1);
        check("abort_pre_psn",   32'(m_retx_psn),   32'h000071);
        qp_open = 1'b0;
        tick();
        check("abort_valid",    32'(m_retx_valid), 32'd0);
        check("abort_tx_allow", 32'(tx_allow),     32'd0);

        // Reset in the middle of RUN.
        open_qp(24'h000080);
        send_pkt(24'h000081);
        check("mid_outstanding", 32'(outstanding), 32'd1);
        check("mid_tx_allow",    32'(tx_allow),    32'd1);
        rst = 1'b1;
        tick();
        check("mrst_tx_allow",    32'(tx_allow),     32'd0);
        check("mrst_retx_valid",  32'(m_retx_valid), 32'd0);
        check("mrst_retx_psn",    32'(m_retx_psn),   32'd0);
        check("mrst_outstanding", 32'(outstanding),  32'd0);
        check("mrst_qp_error",    32'(qp_error),     32'd0);
        rst     = 1'b0;
        qp_open = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/roce_tx_window_ctrl.md
Name: roce_tx_window_ctrl

Overview:
Per-QP transmit flow controller that sits between the RDMA-write TX packet generator and the QP state tracker.
- Counts outstanding (unacknowledged) PSNs against a window limit and gates new packet issue.
- Runs an ACK timeout with bounded retries.
- On timeout or NAK (stop_transfer) it issues a go-back-N retransmit request starting at last_acked_psn+1.
- Flags a fatal QP error when retries are exhausted.

Parameters:
MAX_OUTSTANDING, 64, max unacked packets before tx_allow deasserts (1..2^23)
TIMEOUT_CYCLES, 1000000, clk cycles without ACK progress before retransmit (>=2)
MAX_RETRIES, 7, consecutive retransmits tolerated before error (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, synchronous, active-high
qp_open  in  1  level; QP connected and transfers permitted
s_tx_pkt_valid  in  1  one-cycle strobe per BTH sent on this QP
s_tx_pkt_psn  in  24  PSN of that packet
last_acked_psn  in  24  latest acknowledged PSN from QP state tracker
stop_transfer  in  1  NAK indication from QP state tracker
tx_allow  out  1  packet generator may start a new packet
m_retx_valid  out  1  retransmit request valid
m_retx_ready  in  1  retransmit request accepted
m_retx_psn  out  24  first PSN to replay
outstanding  out  24  (last_sent - last_acked) mod 2^24
qp_error  out  1  retries exhausted; sticky until qp_open low

Behaviour:
- Reset values: tx_allow=0, m_retx_valid=0, m_retx_psn=0, outstanding=0, qp_error=0, state=IDLE, timer=0, retries=0.
- All PSN arithmetic is mod 2^24. 0xFFFFFF+1 = 0. outstanding = (last_sent_reg - acked_reg) mod 2^24, registered.
- acked_reg samples last_acked_psn every cycle. ACK progress means last_acked_psn != acked_reg.
- States:
  - IDLE: tx_allow=0. If qp_open=1: last_sent_reg <= last_acked_psn, acked_reg <= last_acked_psn, timer/retries <= 0, go to RUN.
  - RUN: tx_allow = (outstanding < MAX_OUTSTANDING) and no pending event.
    - s_tx_pkt_valid: last_sent_reg <= s_tx_pkt_psn. Tracked in any non-IDLE state, even when tx_allow=0.
    - Timer increments while outstanding != 0. It clears on ACK progress or when outstanding == 0.
    - ACK progress also clears retries.
    - Event is stop_transfer=1, or timer == TIMEOUT_CYCLES-1 with no ACK progress that cycle:
      - retries == MAX_RETRIES: go to ERROR.
      - otherwise: retries++, m_retx_psn <= last_acked_psn+1, go to RETX.
  - RETX: tx_allow=0, m_retx_valid=1. m_retx_psn is held stable until handshake.
    - On m_retx_valid & m_retx_ready: last_sent_reg <= acked_reg (outstanding=0), timer <= 0, go to RUN.
    - stop_transfer in RETX is ignored.
  - ERROR: tx_allow=0, qp_error=1, m_retx_valid=0.
- qp_open=0 in any state: next state IDLE, qp_error cleared, m_retx_valid dropped without handshake (abort is permitted). This has priority over every other event.
- Simultaneous events:
  - ACK progress and timeout in the same cycle: ACK wins, no retransmit.
  - stop_transfer and timeout in the same cycle: one retransmit, retries +1 only.
  - s_tx_pkt_valid and event in the same cycle: last_sent is updated, then the event is taken.
- Latency:
  - tx_allow reflects registered outstanding, one cycle after a pkt strobe. Overshoot of MAX_OUTSTANDING by at most 1 is legal.
  - Event to m_retx_valid: 1 cycle.
- rst mid-operation returns to reset values regardless of state.

Decomposition:
- Shared package roce_qp_pkg: PSN_WIDTH=24, state encodings (IDLE, RUN, RETX, ERROR), function psn_diff(a,b) returning (a-b) mod 2^24. The opcode localparams (RC_RDMA_WRITE_*, RC_RDMA_ACK) move to the package too.
- Sub-module roce_ack_timer: timer, retry counter and timeout/exhausted flags. Inputs: clear/progress/enable/retry_inc.

Test Plan:
- Open with last_acked_psn=0x000010; send PSNs 0x11..0x50 (64 pkts), no ACK -> outstanding=64, tx_allow=0; set last_acked_psn=0x30 -> outstanding=32, tx_allow=1 next cycle.
- Wrap: last_acked_psn=0xFFFFF0, send PSNs through 0x000005 -> outstanding=0x15; ACK to 0x000005 -> outstanding=0.
- TIMEOUT_CYCLES=100, one pkt PSN 0x21 unacked -> cycle 100 m_retx_valid=1, m_retx_psn=0x21; hold ready=0 20 cycles -> psn stable; ready=1 -> RUN, outstanding=0.
- stop_transfer pulse with last_acked_psn=0x40 -> m_retx_psn=0x41 next cycle; stop_transfer and timeout same cycle -> single request, retries=1.
- MAX_RETRIES=2, never ACK -> 2 retransmits, third timeout -> qp_error=1, tx_allow=0; qp_open=0 -> IDLE, qp_error=0.
- qp_open deasserted during RETX with ready=0 -> m_retx_valid=0 next cycle; rst mid-RUN -> all outputs 0.
